// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: operation codes, FSM states, datapath width.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU: ADD/SUB/AND/OR with carry-out and borrow flags.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              borrow
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide     = '0;
    result   = '0;
    overflow = 1'b0;
    borrow   = 1'b0;
    case (op)
      ALU_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        result   = wide[DATA_W-1:0];
        overflow = wide[DATA_W];
      end
      // The top bit of the widened difference is set exactly when a < b (unsigned).
      ALU_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        borrow = wide[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter serialising requests through the shared ALU (IDLE -> EXEC -> RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_overflow,
  output logic              rsp0_borrow,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_overflow,
  output logic              rsp1_borrow,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              last_grant;
  logic              owner;
  logic              grant;
  logic              accept;
  logic              rsp_fire;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] result_q;
  logic              overflow_q, borrow_q;
  logic              busy_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow, alu_borrow;

  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_result),
    .overflow (alu_overflow),
    .borrow   (alu_borrow)
  );

  // On a tie the port that was not served last wins.
  always_comb begin
    grant = last_grant;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
    else if (req0_valid && req1_valid)
      grant = ~last_grant;
  end

  always_comb begin
    req0_ready = (state == ST_IDLE) && req0_valid && (grant == 1'b0);
    req1_ready = (state == ST_IDLE) && req1_valid && (grant == 1'b1);
    accept     = req0_ready || req1_ready;
    rsp0_valid = (state == ST_RESP) && (owner == 1'b0);
    rsp1_valid = (state == ST_RESP) && (owner == 1'b1);
    rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)   state_nxt = ST_EXEC;
      ST_EXEC:               state_nxt = ST_RESP;
      ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      borrow_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      if (accept) begin
        owner <= grant;
        a_q   <= grant ? req1_a  : req0_a;
        b_q   <= grant ? req1_b  : req0_b;
        op_q  <= grant ? req1_op : req0_op;
      end
      if (state == ST_EXEC) begin
        result_q   <= alu_result;
        overflow_q <= alu_overflow;
        borrow_q   <= alu_borrow;
      end
      if (rsp_fire)
        last_grant <= owner;
    end
  end

  assign busy          = busy_q;
  assign rsp0_result   = result_q;
  assign rsp0_overflow = overflow_q;
  assign rsp0_borrow   = borrow_q;
  assign rsp1_result   = result_q;
  assign rsp1_overflow = overflow_q;
  assign rsp1_borrow   = borrow_q;

endmodule
